shared_mem_batched: RTL and testbench



---
 rtl/smem_pkg.sv | 27 ++
 rtl/smem_bank_sched.sv | 55 +++++
 rtl/shared_mem_batched.sv | 214 +++++++++++++++++++++
 tb/tb_shared_mem_batched.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/smem_pkg.sv
// Shared definitions for the batched banked scratchpad: FSM states and address helpers.
package smem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StResp
    } smem_state_e;

    function automatic int unsigned calc_addr_w(int unsigned size, int unsigned word_size);
        return $clog2(size / word_size);
    endfunction

    function automatic int unsigned calc_bank_bits(int unsigned num_banks);
        return $clog2(num_banks);
    endfunction

    function automatic int unsigned bank_of(logic [31:0] addr, int unsigned bank_bits);
        return addr & ((32'd1 << bank_bits) - 32'd1);
    endfunction

    function automatic int unsigned row_of(logic [31:0] addr, int unsigned bank_bits);
        return addr >> bank_bits;
    endfunction

endpackage

// File: rtl/smem_bank_sched.sv
// Per-bank grant picker: the lowest pending lane mapped to this bank wins.
// With SMEM_BCAST_EN defined, read lanes sharing the winner's full address join the grant.
module smem_bank_sched
    import smem_pkg::*;
#(
    parameter int unsigned NUM_REQS  = 4,
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned BANK_BITS = 2,
    parameter int unsigned BANK_W    = 2,
    parameter int unsigned ROW_W     = 10,
    parameter int unsigned BANK_ID   = 0
) (
    input  logic [NUM_REQS-1:0]             pending_i,
    input  logic                            is_read_i,
    input  logic [NUM_REQS-1:0][BANK_W-1:0] lane_bank_i,
    input  logic [NUM_REQS-1:0][ADDR_W-1:0] lane_addr_i,
    output logic                            gnt_valid_o,
    output logic [NUM_REQS-1:0]             gnt_mask_o,
    output logic [ROW_W-1:0]                row_o
);

    logic              found;
    logic [ADDR_W-1:0] sel_addr;
    logic              unused_is_read;

    always_comb begin
        found      = 1'b0;
        sel_addr   = '0;
        gnt_mask_o = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (!found && pending_i[i] && (lane_bank_i[i] == BANK_W'(BANK_ID))) begin
                found         = 1'b1;
                sel_addr      = lane_addr_i[i];
                gnt_mask_o[i] = 1'b1;
            end
        end
`ifdef SMEM_BCAST_EN
        unused_is_read = 1'b0;
        // Same full address implies same bank, so no bank compare is needed here.
        if (found && is_read_i) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (pending_i[i] && (lane_addr_i[i] == sel_addr)) begin
                    gnt_mask_o[i] = 1'b1;
                end
            end
        end
`else
        unused_is_read = is_read_i;
`endif
    end

    assign gnt_valid_o = found;
    assign row_o       = ROW_W'(row_of(32'(sel_addr), BANK_BITS));

endmodule

// File: rtl/shared_mem_batched.sv
// Banked scratchpad taking one warp-wide request per batch and serializing bank conflicts.
// Define SMEM_BCAST_EN to let read lanes hitting the same address share one bank grant.
module shared_mem_batched
    import smem_pkg::*;
#(
    parameter int unsigned NUM_REQS  = 4,
    parameter int unsigned NUM_BANKS = 4,
    parameter int unsigned WORD_SIZE = 4,
    parameter int unsigned SIZE      = 16384,
    parameter int unsigned TAG_WIDTH = 10,
    parameter int unsigned ADDR_W    = calc_addr_w(SIZE, WORD_SIZE)
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            req_valid,
    input  logic                            req_rw,
    input  logic [NUM_REQS-1:0]             req_tmask,
    input  logic [NUM_REQS*ADDR_W-1:0]      req_addr,
    input  logic [NUM_REQS*WORD_SIZE-1:0]   req_byteen,
    input  logic [NUM_REQS*8*WORD_SIZE-1:0] req_data,
    input  logic [TAG_WIDTH-1:0]            req_tag,
    output logic                            req_ready,
    output logic                            rsp_valid,
    output logic [NUM_REQS-1:0]             rsp_tmask,
    output logic [NUM_REQS*8*WORD_SIZE-1:0] rsp_data,
    output logic [TAG_WIDTH-1:0]            rsp_tag,
    input  logic                            rsp_ready
);

    localparam int unsigned BANK_BITS = calc_bank_bits(NUM_BANKS);
    localparam int unsigned BANK_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int unsigned ROW_W     = ADDR_W - BANK_BITS;
    localparam int unsigned BANK_ROWS = 2 ** ROW_W;
    localparam int unsigned DATA_W    = 8 * WORD_SIZE;

    smem_state_e state_q, state_d;
    logic                                  rw_q, rw_d;
    logic [NUM_REQS-1:0]                   tmask_q, tmask_d;
    logic [NUM_REQS-1:0][ADDR_W-1:0]       addr_q, addr_d;
    logic [NUM_REQS-1:0][WORD_SIZE-1:0]    byteen_q, byteen_d;
    logic [NUM_REQS-1:0][DATA_W-1:0]       data_q, data_d;
    logic [TAG_WIDTH-1:0]                  tag_q, tag_d;
    logic [NUM_REQS-1:0]                   pending_q, pending_d;
    logic [NUM_BANKS-1:0][NUM_REQS-1:0]    rd_mask_q, rd_mask_d;
    logic [NUM_REQS-1:0][DATA_W-1:0]       rsp_data_q, rsp_data_d;

    logic [NUM_REQS-1:0][BANK_W-1:0] lane_bank;
    logic                            gnt_valid  [NUM_BANKS];
    logic [NUM_REQS-1:0]             gnt_mask   [NUM_BANKS];
    logic [ROW_W-1:0]                gnt_row    [NUM_BANKS];
    logic                            bank_en    [NUM_BANKS];
    logic [DATA_W-1:0]               bank_wdata [NUM_BANKS];
    logic [WORD_SIZE-1:0]            bank_be    [NUM_BANKS];
    logic [DATA_W-1:0]               bank_rdata [NUM_BANKS];
    logic [NUM_REQS-1:0]             gnt_any;

    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            lane_bank[i] = BANK_W'(bank_of(32'(addr_q[i]), BANK_BITS));
        end
    end

    // Write grants are one-hot; the descending scan leaves the lowest granted lane selected.
    always_comb begin
        gnt_any = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_en[b]    = (state_q == StIssue) && gnt_valid[b];
            bank_wdata[b] = '0;
            bank_be[b]    = '0;
            gnt_any       = gnt_any | gnt_mask[b];
            for (int i = NUM_REQS - 1; i >= 0; i--) begin
                if (gnt_mask[b][i]) begin
                    bank_wdata[b] = data_q[i];
                    bank_be[b]    = byteen_q[i];
                end
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_W-1:0] mem_q [BANK_ROWS];
        logic [DATA_W-1:0] rdata_q;

        smem_bank_sched #(
            .NUM_REQS (NUM_REQS),
            .ADDR_W   (ADDR_W),
            .BANK_BITS(BANK_BITS),
            .BANK_W   (BANK_W),
            .ROW_W    (ROW_W),
            .BANK_ID  (b)
        ) u_sched (
            .pending_i  (pending_q),
            .is_read_i  (~rw_q),
            .lane_bank_i(lane_bank),
            .lane_addr_i(addr_q),
            .gnt_valid_o(gnt_valid[b]),
            .gnt_mask_o (gnt_mask[b]),
            .row_o      (gnt_row[b])
        );

        // Single-port RAM: one access per cycle, contents survive reset.
        always_ff @(posedge clk) begin
            if (bank_en[b]) begin
                if (rw_q) begin
                    for (int k = 0; k < WORD_SIZE; k++) begin
                        if (bank_be[b][k]) begin
                            mem_q[gnt_row[b]][k*8 +: 8] <= bank_wdata[b][k*8 +: 8];
                        end
                    end
                end else begin
                    rdata_q <= mem_q[gnt_row[b]];
                end
            end
        end

        assign bank_rdata[b] = rdata_q;
    end

    always_comb begin
        state_d    = state_q;
        rw_d       = rw_q;
        tmask_d    = tmask_q;
        addr_d     = addr_q;
        byteen_d   = byteen_q;
        data_d     = data_q;
        tag_d      = tag_q;
        pending_d  = pending_q;
        rd_mask_d  = '0;
        rsp_data_d = rsp_data_q;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;

        // Read data lands one cycle after its grant, in ISSUE or DRAIN.
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (rd_mask_q[b][i]) begin
                    rsp_data_d[i] = bank_rdata[b];
                end
            end
        end

        unique case (state_q)
            StIdle: begin
                req_ready = reset_n;
                if (req_valid) begin
                    rw_d      = req_rw;
                    tmask_d   = req_tmask;
                    addr_d    = req_addr;
                    byteen_d  = req_byteen;
                    data_d    = req_data;
                    tag_d     = req_tag;
                    pending_d = req_tmask;
                    if (req_tmask != '0) begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                pending_d = pending_q & ~gnt_any;
                if (!rw_q) begin
                    for (int b = 0; b < NUM_BANKS; b++) begin
                        rd_mask_d[b] = gnt_mask[b];
                    end
                end
                if (pending_d == '0) begin
                    state_d = rw_q ? StIdle : StDrain;
                end
            end
            StDrain: begin
                state_d = StResp;
            end
            StResp: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            rw_q       <= 1'b0;
            tmask_q    <= '0;
            addr_q     <= '0;
            byteen_q   <= '0;
            data_q     <= '0;
            tag_q      <= '0;
            pending_q  <= '0;
            rd_mask_q  <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rw_q       <= rw_d;
            tmask_q    <= tmask_d;
            addr_q     <= addr_d;
            byteen_q   <= byteen_d;
            data_q     <= data_d;
            tag_q      <= tag_d;
            pending_q  <= pending_d;
            rd_mask_q  <= rd_mask_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign rsp_tmask = tmask_q;
    assign rsp_tag   = tag_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_shared_mem_batched.sv
// Randomized scoreboard bench for shared_mem_batched; honours SMEM_BCAST_EN if defined.
module tb_shared_mem_batched;

    localparam int unsigned NR = 4;
    localparam int unsigned TW = 10;
`ifdef SMEM_BCAST_EN
    localparam bit BCAST_EN = 1'b1;
`else
    localparam bit BCAST_EN = 1'b0;
`endif

    logic          clk;
    logic          reset_n;
    logic          req_valid;
    logic          req_rw;
    logic [3:0]    req_tmask;
    logic [31:0]   req_addr;
    logic [15:0]   req_byteen;
    logic [127:0]  req_data;
    logic [TW-1:0] req_tag;
    logic          req_ready;
    logic          rsp_valid;
    logic [3:0]    rsp_tmask;
    logic [127:0]  rsp_data;
    logic [TW-1:0] rsp_tag;
    logic          rsp_ready;

    shared_mem_batched #(
        .NUM_REQS (4),
        .NUM_BANKS(4),
        .WORD_SIZE(4),
        .SIZE     (1024),
        .TAG_WIDTH(TW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_rw    (req_rw),
        .req_tmask (req_tmask),
        .req_addr  (req_addr),
        .req_byteen(req_byteen),
        .req_data  (req_data),
        .req_tag   (req_tag),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_tmask (rsp_tmask),
        .rsp_data  (rsp_data),
        .rsp_tag   (rsp_tag),
        .rsp_ready (rsp_ready)
    );

    typedef struct {
        logic [TW-1:0] tag;
        logic [3:0]    tmask;
        logic [127:0]  data;
        int            due;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_mem [256];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          bp_mode = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Cycles the busiest bank needs: lanes per bank, or distinct read addresses when broadcasting.
    function automatic int calc_c(input bit rw, input logic [3:0] tm, input logic [3:0][7:0] a);
        int cnt[4];
        int c;
        bit dup;
        for (int b = 0; b < 4; b++) cnt[b] = 0;
        for (int i = 0; i < 4; i++) begin
            if (tm[i]) begin
                dup = 1'b0;
                if (!rw && BCAST_EN) begin
                    for (int j = 0; j < i; j++) if (tm[j] && a[j] == a[i]) dup = 1'b1;
                end
                if (!dup) cnt[int'(a[i][1:0])]++;
            end
        end
        c = 0;
        for (int b = 0; b < 4; b++) if (cnt[b] > c) c = cnt[b];
        return c;
    endfunction

    task automatic send(input bit rw, input logic [3:0] tm, input logic [3:0][7:0] a,
                        input logic [15:0] be, input logic [127:0] d, input logic [TW-1:0] tag,
                        input bit expect_rsp);
        int   waited;
        int   n;
        int   c;
        exp_t e;
        @(negedge clk);
        waited = 0;
        while (!req_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        chk("req_accept_ready", 128'(req_ready), 128'(1));
        if (!req_ready) return;
        n          = cyc;
        req_valid  = 1'b1;
        req_rw     = rw;
        req_tmask  = tm;
        req_addr   = a;
        req_byteen = be;
        req_data   = d;
        req_tag    = tag;
        @(posedge clk);
        #1 req_valid = 1'b0;
        c = calc_c(rw, tm, a);
        if (tm == 4'b0) begin
            @(negedge clk);
            chk("empty_mask_ready", 128'(req_ready), 128'(1));
        end else if (rw) begin
            for (int i = 0; i < 4; i++) begin
                if (tm[i]) begin
                    for (int k = 0; k < 4; k++) begin
                        if (be[i*4+k]) model_mem[a[i]][k*8 +: 8] = d[i*32+k*8 +: 8];
                    end
                end
            end
            for (int k = 1; k <= c; k++) begin
                @(negedge clk);
                chk("wr_busy_ready", 128'(req_ready), 128'(0));
            end
            @(negedge clk);
            chk("wr_done_ready", 128'(req_ready), 128'(1));
        end else if (expect_rsp) begin
            e.tag   = tag;
            e.tmask = tm;
            e.data  = '0;
            for (int i = 0; i < 4; i++) if (tm[i]) e.data[i*32 +: 32] = model_mem[a[i]];
            e.due = n + c + 2;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || rsp_valid) && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("drain_outstanding", 128'(exp_q.size()), 128'(0));
    endtask

    // Response-side backpressure generator.
    initial begin
        int hi_cnt;
        hi_cnt    = 0;
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            hi_cnt = rsp_valid ? hi_cnt + 1 : 0;
            case (bp_mode)
                1:       rsp_ready = ($urandom_range(0, 2) != 0);
                2:       rsp_ready = (hi_cnt > 5);
                default: rsp_ready = 1'b1;
            endcase
        end
    end

    // Monitor: checks rise timing, hold stability and pops the scoreboard on each fire.
    initial begin
        bit            prev_valid;
        bit            rdy_next;
        logic [127:0]  held_data;
        logic [TW-1:0] held_tag;
        logic [3:0]    held_tmask;
        logic [127:0]  m;
        exp_t          e;
        prev_valid = 1'b0;
        rdy_next   = 1'b0;
        forever begin
            @(negedge clk);
            if (rdy_next) begin
                rdy_next = 1'b0;
                chk("ready_after_fire", 128'(req_ready), 128'(1));
            end
            if (reset_n && rsp_valid) begin
                if (!prev_valid) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_rsp: got rsp_valid=1 tag %0h, required no response (cycle %0d)",
                                 rsp_tag, cyc);
                    end else begin
                        chk("rsp_cycle", 128'(cyc), 128'(exp_q[0].due));
                    end
                end else begin
                    chk("rsp_hold_data", rsp_data, held_data);
                    chk("rsp_hold_tag", 128'(rsp_tag), 128'(held_tag));
                    chk("rsp_hold_tmask", 128'(rsp_tmask), 128'(held_tmask));
                end
                chk("ready_low_in_resp", 128'(req_ready), 128'(0));
                if (rsp_ready) begin
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        m = '0;
                        for (int i = 0; i < NR; i++) if (e.tmask[i]) m[i*32 +: 32] = '1;
                        chk("rsp_tag", 128'(rsp_tag), 128'(e.tag));
                        chk("rsp_tmask", 128'(rsp_tmask), 128'(e.tmask));
                        chk("rsp_data", rsp_data & m, e.data & m);
                    end
                    rdy_next   = 1'b1;
                    prev_valid = 1'b0;
                end else begin
                    prev_valid = 1'b1;
                    held_data  = rsp_data;
                    held_tag   = rsp_tag;
                    held_tmask = rsp_tmask;
                end
            end else begin
                prev_valid = 1'b0;
            end
        end
    end

    initial begin
        logic [3:0][7:0] a;
        logic [127:0]    d;
        logic [3:0]      tm;
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_rw     = 1'b0;
        req_tmask  = '0;
        req_addr   = '0;
        req_byteen = '0;
        req_data   = '0;
        req_tag    = '0;
        repeat (3) @(negedge clk);
        chk("reset_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("reset_req_ready", 128'(req_ready), 128'(0));
        reset_n = 1'b1;
        #1 chk("release_req_ready", 128'(req_ready), 128'(1));

        // Fill every word; words 0..3 get 0x10..0x13.
        for (int k = 0; k < 64; k++) begin
            for (int i = 0; i < 4; i++) begin
                a[i]           = 8'(4 * k + i);
                d[i*32 +: 32]  = (k == 0) ? 32'(32'h10 + i) : $urandom;
            end
            send(1'b1, 4'b1111, a, 16'hffff, d, '0, 1'b1);
        end

        send(1'b0, 4'b1111, {8'd3, 8'd2, 8'd1, 8'd0}, '0, '0, 10'h2a, 1'b1);
        send(1'b0, 4'b1111, {8'd12, 8'd8, 8'd4, 8'd0}, '0, '0, 10'h001, 1'b1);
        send(1'b0, 4'b1111, {8'd5, 8'd5, 8'd5, 8'd5}, '0, '0, 10'h002, 1'b1);
        send(1'b1, 4'b1001, {8'd7, 8'd7, 8'd7, 8'd7}, 16'hffff,
             {32'hbbbbbbbb, 32'h0, 32'h0, 32'haaaaaaaa}, '0, 1'b1);
        send(1'b0, 4'b1111, {8'd7, 8'd7, 8'd7, 8'd7}, '0, '0, 10'h003, 1'b1);
        send(1'b1, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd7}, 16'h0003, {96'h0, 32'h11223344}, '0, 1'b1);
        send(1'b0, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd7}, '0, '0, 10'h004, 1'b1);
        drain();

        bp_mode = 2;
        send(1'b0, 4'b1111, {8'd12, 8'd11, 8'd10, 8'd9}, '0, '0, 10'h005, 1'b1);
        drain();
        bp_mode = 0;

        // Reset while a fully conflicted read is in ISSUE.
        send(1'b0, 4'b1111, {8'd12, 8'd8, 8'd4, 8'd0}, '0, '0, 10'h3ff, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midreset_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("midreset_req_ready", 128'(req_ready), 128'(0));
        repeat (2) @(negedge clk);
        chk("midreset_rsp_valid_hold", 128'(rsp_valid), 128'(0));
        reset_n = 1'b1;
        #1 chk("midreset_release_ready", 128'(req_ready), 128'(1));
        send(1'b0, 4'b1111, {8'd12, 8'd8, 8'd4, 8'd0}, '0, '0, 10'h006, 1'b1);
        send(1'b0, 4'b0000, {8'd1, 8'd2, 8'd3, 8'd4}, '0, '0, 10'h007, 1'b1);
        drain();

        bp_mode = 1;
        for (int t = 0; t < 150; t++) begin
            for (int i = 0; i < 4; i++) begin
                a[i] = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 15))
                                                   : 8'($urandom_range(0, 255));
            end
            tm = 4'($urandom);
            d  = {$urandom, $urandom, $urandom, $urandom};
            send(1'($urandom), tm, a, 16'($urandom), d, TW'($urandom), 1'b1);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
